// File: rtl/sfifo_pkt.sv
// Packet-aware single-clock FIFO: words become visible to the reader only once their
// packet's last word is committed; the writer can abort or lose a whole packet to overflow.
module sfifo_pkt #(
    parameter int BW     = 32,
    parameter int LGFLEN = 4,
    parameter int AFULL  = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_last,
    input  logic              i_abort,
    output logic              o_full,
    output logic              o_afull,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_overflow,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_last,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_pkts
);

    localparam int              FLEN    = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FLEN_W  = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN:0] AFULL_W = (LGFLEN+1)'(AFULL);

    typedef enum logic {
        WR_ACCEPT,
        WR_DROP
    } wr_state_t;

    logic [BW:0]     mem [FLEN];
    logic [LGFLEN:0] wr_addr, commit_addr, rd_addr;
    logic [LGFLEN:0] wr_next, commit_next, rd_next, fill_next;
    wr_state_t       wr_state;
    logic            dropping;
    logic            w_wr, w_rd, w_commit;
    logic            drop_start, drop_end, rollback;

    assign dropping = (wr_state == WR_DROP);

    always_comb begin
        w_wr       = i_wr && !o_full && !dropping && !i_abort;
        w_rd       = i_rd && !o_empty;
        w_commit   = w_wr && i_last;
        // A write hitting a full FIFO poisons the whole packet; a last word ends the drop,
        // even when that overflowing word is itself the last one.
        drop_end   = i_wr && i_last && !i_abort && (dropping || o_full);
        drop_start = i_wr && !i_last && !i_abort && o_full && !dropping;
        rollback   = i_abort || drop_end;

        wr_next = wr_addr;
        if (rollback)
            wr_next = commit_addr;
        else if (w_wr)
            wr_next = wr_addr + 1'b1;

        commit_next = w_commit ? wr_addr + 1'b1 : commit_addr;
        rd_next     = w_rd ? rd_addr + 1'b1 : rd_addr;
        fill_next   = wr_next - rd_next;
    end

    always_ff @(posedge i_clk) begin
        if (w_wr)
            mem[wr_addr[LGFLEN-1:0]] <= {i_last, i_data};
    end

    assign {o_last, o_data} = mem[rd_addr[LGFLEN-1:0]];
    assign o_afull          = (o_fill >= AFULL_W);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_addr     <= '0;
            commit_addr <= '0;
            rd_addr     <= '0;
            wr_state    <= WR_ACCEPT;
            o_fill      <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_pkts      <= '0;
            o_overflow  <= 1'b0;
        end else begin
            wr_addr     <= wr_next;
            commit_addr <= commit_next;
            rd_addr     <= rd_next;
            o_fill      <= fill_next;
            o_full      <= (fill_next == FLEN_W);
            o_empty     <= (rd_next == commit_next);
            o_overflow  <= drop_end;

            if (rollback)
                wr_state <= WR_ACCEPT;
            else if (drop_start)
                wr_state <= WR_DROP;

            // Committing one packet while finishing another leaves the count unchanged.
            case ({w_commit, w_rd && o_last})
                2'b10:   o_pkts <= o_pkts + 1'b1;
                2'b01:   o_pkts <= o_pkts - 1'b1;
                default: o_pkts <= o_pkts;
            endcase
        end
    end

    a_fill_bound: assert property (@(posedge i_clk) disable iff (i_reset)
        o_fill <= FLEN_W);
    a_pkts_empty: assert property (@(posedge i_clk) disable iff (i_reset)
        (o_pkts == '0) |-> o_empty);
    a_ptr_order: assert property (@(posedge i_clk) disable iff (i_reset)
        (commit_addr - rd_addr) <= (wr_addr - rd_addr));

endmodule

// File: tb/tb_sfifo_pkt.sv
// Directed bench for sfifo_pkt (depth 8, almost-full at 5): a vector table for the
// basic commit/abort/afull cases plus sequences for overflow, pointer wrap and reset.
module tb_sfifo_pkt;

    localparam int BW     = 32;
    localparam int LGFLEN = 3;
    localparam int AFULL  = 5;

    logic              i_clk = 1'b0;
    logic              i_reset, i_wr, i_last, i_abort, i_rd;
    logic [BW-1:0]     i_data;
    logic              o_full, o_afull, o_overflow, o_last, o_empty;
    logic [LGFLEN:0]   o_fill, o_pkts;
    logic [BW-1:0]     o_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    sfifo_pkt #(.BW(BW), .LGFLEN(LGFLEN), .AFULL(AFULL)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_data(i_data),
        .i_last(i_last), .i_abort(i_abort), .o_full(o_full), .o_afull(o_afull),
        .o_fill(o_fill), .o_overflow(o_overflow), .i_rd(i_rd), .o_data(o_data),
        .o_last(o_last), .o_empty(o_empty), .o_pkts(o_pkts)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst, wr;
        logic [31:0] data;
        logic        last, abort, rd;
        logic [3:0]  fill;
        logic        empty;
        logic [3:0]  pkts;
        logic        full, afull, ovf, chk_head;
        logic [31:0] hdata;
        logic        hlast;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic wr, logic [31:0] data, logic last,
                                logic abort, logic rd, logic [3:0] fill, logic empty,
                                logic [3:0] pkts, logic full, logic afull, logic ovf,
                                logic chk_head, logic [31:0] hdata, logic hlast);
        vec_t v;
        v.rst = rst; v.wr = wr; v.data = data; v.last = last; v.abort = abort; v.rd = rd;
        v.fill = fill; v.empty = empty; v.pkts = pkts; v.full = full; v.afull = afull;
        v.ovf = ovf; v.chk_head = chk_head; v.hdata = hdata; v.hlast = hlast;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input int fill, input logic empty,
                              input int pkts, input logic full, input logic afull,
                              input logic ovf);
        checkOutput({tag, ".fill"}, 32'(o_fill), 32'(fill));
        checkOutput({tag, ".empty"}, 32'(o_empty), 32'(empty));
        checkOutput({tag, ".pkts"}, 32'(o_pkts), 32'(pkts));
        checkOutput({tag, ".full"}, 32'(o_full), 32'(full));
        checkOutput({tag, ".afull"}, 32'(o_afull), 32'(afull));
        checkOutput({tag, ".overflow"}, 32'(o_overflow), 32'(ovf));
    endtask

    task automatic checkHead(input string tag, input logic [31:0] data, input logic last);
        checkOutput({tag, ".data"}, o_data, data);
        checkOutput({tag, ".last"}, 32'(o_last), 32'(last));
    endtask

    // Drives one cycle of inputs, then waits until just after the edge that consumes them.
    task automatic applyStimulus(input logic rst, input logic wr, input logic [31:0] data,
                                 input logic last, input logic abort, input logic rd);
        i_reset = rst; i_wr = wr; i_data = data; i_last = last; i_abort = abort; i_rd = rd;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic [31:0] model_q[$];
        logic        rd_eff;

        i_reset = 1'b1; i_wr = 1'b0; i_data = '0; i_last = 1'b0; i_abort = 1'b0; i_rd = 1'b0;

        // rst wr data last abort rd | fill empty pkts full afull ovf | chk hdata hlast
        vecs.push_back(mk(1,0,32'h0 ,0,0,0, 0,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hA0,0,0,0, 1,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hB1,0,0,0, 2,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hC2,1,0,0, 3,0,1,0,0,0, 1,32'hA0,0));
        vecs.push_back(mk(0,0,32'h0 ,0,0,1, 2,0,1,0,0,0, 1,32'hB1,0));
        vecs.push_back(mk(0,0,32'h0 ,0,0,1, 1,0,1,0,0,0, 1,32'hC2,1));
        vecs.push_back(mk(0,0,32'h0 ,0,0,1, 0,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,0,32'h0 ,0,0,1, 0,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hD1,0,0,0, 1,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hD2,0,0,0, 2,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hE3,0,1,0, 0,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,0,32'h0 ,0,0,1, 0,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hD4,1,0,0, 1,0,1,0,0,0, 1,32'hD4,1));
        vecs.push_back(mk(0,0,32'h0 ,0,0,1, 0,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'h50,0,0,0, 1,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'h51,0,0,0, 2,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'h52,0,0,0, 3,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'h53,0,0,0, 4,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'h54,0,0,0, 5,1,0,0,1,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,0,32'h0 ,0,1,0, 0,1,0,0,0,0, 0,32'h0 ,0));
        vecs.push_back(mk(0,1,32'hF6,1,0,0, 1,0,1,0,0,0, 1,32'hF6,1));
        vecs.push_back(mk(0,1,32'h67,1,0,1, 1,0,1,0,0,0, 1,32'h67,1));
        vecs.push_back(mk(0,0,32'h0 ,0,0,1, 0,1,0,0,0,0, 0,32'h0 ,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].last,
                          vecs[i].abort, vecs[i].rd);
            checkState($sformatf("vec%0d", i), int'(vecs[i].fill), vecs[i].empty,
                       int'(vecs[i].pkts), vecs[i].full, vecs[i].afull, vecs[i].ovf);
            if (vecs[i].chk_head)
                checkHead($sformatf("vec%0d", i), vecs[i].hdata, vecs[i].hlast);
        end

        // Overflow: a committed 6-word packet, then a 4-word packet that runs out of room.
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 1, 32'h200 + i, (i == 5), 0, 0);
        checkState("ovf.first", 6, 0, 1, 0, 1, 0);
        applyStimulus(0, 1, 32'h300, 0, 0, 0);
        applyStimulus(0, 1, 32'h301, 0, 0, 0);
        checkState("ovf.filled", 8, 0, 1, 1, 1, 0);
        applyStimulus(0, 1, 32'h302, 0, 0, 0);
        checkState("ovf.dropping", 8, 0, 1, 1, 1, 0);
        applyStimulus(0, 1, 32'h303, 1, 0, 0);
        checkState("ovf.end", 6, 0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkState("ovf.pulse_done", 6, 0, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            checkHead($sformatf("ovf.rd%0d", i), 32'h200 + i, (i == 5));
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        checkState("ovf.drained", 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h3A5, 1, 0, 0);
        checkState("ovf.resume", 1, 0, 1, 0, 0, 0);
        checkHead("ovf.resume", 32'h3A5, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Pointer wrap: a single-word packet every cycle with the reader always on.
        applyStimulus(1, 0, 0, 0, 0, 0);
        model_q.delete();
        for (int c = 0; c < 20; c++) begin
            rd_eff = (model_q.size() > 0);
            if (rd_eff)
                checkHead($sformatf("wrap%0d", c), model_q[0], 1);
            applyStimulus(0, 1, 32'h400 + c, 1, 0, 1);
            if (rd_eff)
                void'(model_q.pop_front());
            model_q.push_back(32'h400 + c);
            checkState($sformatf("wrap%0d", c), model_q.size(), 0, model_q.size(), 0, 0, 0);
        end
        checkHead("wrap.tail", 32'h400 + 19, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkState("wrap.drained", 0, 1, 0, 0, 0, 0);

        // Reset while two packets are pending and the writer is dropping an overflow.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h500, 0, 0, 0);
        applyStimulus(0, 1, 32'h501, 1, 0, 0);
        applyStimulus(0, 1, 32'h502, 1, 0, 0);
        checkState("rst.pending", 3, 0, 2, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 32'h510 + i, 0, 0, 0);
        applyStimulus(0, 1, 32'h51F, 0, 0, 0);
        checkState("rst.dropping", 8, 0, 2, 1, 1, 0);
        applyStimulus(1, 1, 32'h520, 0, 0, 0);
        checkState("rst.after", 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h600, 1, 0, 0);
        checkState("rst.resume", 1, 0, 1, 0, 0, 0);
        checkHead("rst.resume", 32'h600, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkState("rst.drained", 0, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sfifo_pkt.md
Name: sfifo_pkt

Overview:
- Packet-aware synchronous FIFO; the next generation of the team's single-clock data FIFO.
- Adds a per-word end-of-packet flag, packet commit, writer-side abort/rollback, overflow-drop of whole packets, a committed-packet count and a programmable almost-full flag.
- Sits between the SATA link layer (writer, which may abort a FIS on CRC/R_ERR) and the transport layer (reader). The reader never sees an uncommitted or partial packet.

Parameters:
- BW, 32, data word width in bits.
- LGFLEN, 4, log2 of depth; FLEN = 2^LGFLEN words.
- AFULL, 12, almost-full threshold in words, 1..FLEN.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- i_wr  input  1  write strobe.
- i_data  input  BW  write data.
- i_last  input  1  marks i_data as final word of its packet.
- i_abort  input  1  discard the current uncommitted packet.
- o_full  output  1  no free word.
- o_afull  output  1  o_fill >= AFULL.
- o_fill  output  LGFLEN+1  words held, committed plus uncommitted.
- o_overflow  output  1  one-cycle pulse: a packet was dropped for overflow.
- i_rd  input  1  read strobe.
- o_data  output  BW  head-of-FIFO data, asynchronous read.
- o_last  output  1  head word is the last word of its packet.
- o_empty  output  1  no committed word available.
- o_pkts  output  LGFLEN+1  committed packets not yet fully read.

Behaviour:
- Storage: FLEN x (BW+1) memory holding {last, data}.
- Pointers: wr_addr, commit_addr and rd_addr, each LGFLEN+1 bits. Pointers wrap modulo 2^(LGFLEN+1); memory is indexed by the low LGFLEN bits.
- Reset (i_clk edge with i_reset high): all pointers 0, dropping=0, o_fill=0, o_full=0, o_afull=0 (AFULL>0), o_empty=1, o_pkts=0, o_overflow=0.
- o_data/o_last are don't-care while o_empty. Reset does not clear memory.
- Write acceptance: w_wr = i_wr && !o_full && !dropping && !i_abort. An accepted word is stored at wr_addr and wr_addr increments.
- Commit: on w_wr with i_last, commit_addr <= wr_addr+1 and o_pkts increments.
- Abort (highest write-side priority): wr_addr <= commit_addr and dropping <= 0. Any i_wr in that cycle is discarded. o_overflow is not pulsed.
- Overflow: i_wr && o_full && !i_abort sets dropping=1 (no data stored).
  - While dropping, further writes are ignored.
  - The drop ends on the first i_wr && i_last, including the overflowing word itself. At that edge wr_addr <= commit_addr, dropping <= 0, and o_overflow pulses high for exactly the next cycle.
- Read: w_rd = i_rd && !o_empty; rd_addr increments on w_rd.
  - Reading a word with last=1 decrements o_pkts.
  - A simultaneous commit and last-word read leaves o_pkts unchanged.
- o_empty is registered and equals (rd_addr == commit_addr). A committing write at edge N makes o_empty=0 from cycle N+1; there is no read-on-empty bypass.
- o_fill is registered and equals wr_addr - rd_addr after each edge, including after abort/drop rollback, which frees space in one cycle.
- o_full is registered and equals (o_fill == FLEN). i_rd does not unblock a write in the same cycle.
- o_afull is combinational from o_fill.
- Simultaneous events:
  - A read concurrent with abort/drop is unaffected, since reads touch only committed data.
  - Write and read in the same cycle keep o_fill constant.
- Invariants (formal):
  - rd_addr <= commit_addr <= wr_addr in wrap distance.
  - o_fill <= FLEN.
  - o_pkts equals the count of last-flagged words between rd_addr and commit_addr.
  - o_pkts==0 implies o_empty.

Test Plan:
- LGFLEN=3. Write 3 words A,B,C with C last -> o_empty=1 through the edge writing C, 0 next cycle; o_pkts=1; reads return A,B,C with o_last only on C; afterwards o_empty=1 and o_pkts=0.
- Write 2 words, assert i_abort with a 3rd i_wr in the same cycle -> o_fill returns 0, o_empty stays 1, nothing is readable; the next 1-word packet D (last) reads back D.
- Commit a 6-word packet, then write a 4-word packet unread -> 3rd word of the second packet finds o_full=1 and dropping starts; on its last word o_overflow pulses 1 cycle, o_fill=6, and the reader gets exactly the first 6 words.
- AFULL=5: write 5 words with no last -> o_afull asserts the cycle after the 5th write, o_empty stays 1; i_abort -> o_afull=0 and o_fill=0 next cycle.
- Continuous single-word packets with i_rd held high for 20 cycles -> pointer wrap is exercised; data stays in order; o_pkts stays <=1; no overflow.
- i_reset asserted mid-packet with 2 committed packets pending -> next cycle o_empty=1, o_fill=0, o_pkts=0, o_full=0, and the dropping state is cleared.
